// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds (sample, coefficient) pairs into a DSP48A1-style
// slice, accumulates N_TAPS products, drains the slice pipeline and returns
// the slice P output as one result beat on a valid/ready port.
// Optional feature macro: DSP_MAC_SAT_EN adds result saturation to SAT_W bits
// and the R_SAT flag port.
module dsp_mac_sequencer #(
  parameter int unsigned N_TAPS = 8,
  parameter int unsigned LAT    = 3,
  parameter int unsigned SAT_W  = 36
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [17:0] S_SAMPLE,
  input  logic [17:0] S_COEF,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  output logic        DSP_RST,
  input  logic [47:0] DSP_P,
  output logic        R_VALID,
  input  logic        R_READY,
  output logic [47:0] R_DATA
`ifdef DSP_MAC_SAT_EN
  ,
  output logic        R_SAT
`endif
);

  // Slice OPMODE codes (pre-adder bypassed)
  localparam logic [7:0] OP_FIRST = 8'h1E; // P = M + 0
  localparam logic [7:0] OP_ACC   = 8'h16; // P = P + M
  localparam logic [7:0] OP_HOLD  = 8'h17; // P = P + 0
  localparam logic [7:0] OP_IDLE  = 8'h1F;

  // Drain counter runs 0 .. LAT-1
  localparam int unsigned DRAIN_W = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT - 1);
  localparam logic [7:0]         TAP_LAST   = 8'(N_TAPS - 1);

`ifdef DSP_MAC_SAT_EN
  localparam logic [47:0] SAT_MAX = (48'd1 << SAT_W) - 48'd1;
`endif

  if (N_TAPS < 2 || N_TAPS > 255 || LAT < 1 || SAT_W < 1 || SAT_W > 47) begin : g_param_check
    $error("dsp_mac_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t               state_q, state_d;
  logic [7:0]           tap_q, tap_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 r_valid_q, r_valid_d;
  logic [47:0]          r_data_q, r_data_d;
`ifdef DSP_MAC_SAT_EN
  logic                 r_sat_q, r_sat_d;
`endif
  logic                 s_rdy;

  // Slice reset follows the block reset directly so a mid-frame reset flushes it
  assign DSP_RST = RST;
  assign R_VALID = r_valid_q;
  assign R_DATA  = r_data_q;
`ifdef DSP_MAC_SAT_EN
  assign R_SAT   = r_sat_q;
`endif

  // Next-state, slice control and result capture
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    drain_d    = drain_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
`ifdef DSP_MAC_SAT_EN
    r_sat_d    = r_sat_q;
`endif
    s_rdy      = 1'b0;
    DSP_CE     = 1'b0;
    DSP_OPMODE = OP_IDLE;
    DSP_A      = '0;
    DSP_B      = '0;

    if (r_valid_q && R_READY) begin
      r_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        s_rdy = !(r_valid_q && !R_READY);
        DSP_A = S_SAMPLE;
        DSP_B = S_COEF;
        if (S_VALID && s_rdy) begin
          DSP_CE     = 1'b1;
          DSP_OPMODE = OP_FIRST;
          tap_d      = 8'd1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        s_rdy      = 1'b1;
        DSP_A      = S_SAMPLE;
        DSP_B      = S_COEF;
        DSP_OPMODE = OP_ACC;
        if (S_VALID) begin
          DSP_CE = 1'b1;
          tap_d  = tap_q + 8'd1;
          if (tap_q == TAP_LAST) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        DSP_CE     = 1'b1;
        DSP_OPMODE = OP_HOLD;
        if (drain_q == DRAIN_LAST) begin
          r_valid_d = 1'b1;
`ifdef DSP_MAC_SAT_EN
          if (DSP_P > SAT_MAX) begin
            r_data_d = SAT_MAX;
            r_sat_d  = 1'b1;
          end else begin
            r_data_d = DSP_P;
            r_sat_d  = 1'b0;
          end
`else
          r_data_d  = DSP_P;
`endif
          state_d   = HOLD;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      HOLD: begin
        if (R_READY) begin
          state_d = IDLE;
        end
      end
    endcase

    // Reset wins over any concurrent accept: slice sees an idle, frozen pipeline
    if (RST) begin
      s_rdy      = 1'b0;
      DSP_CE     = 1'b0;
      DSP_OPMODE = OP_IDLE;
      DSP_A      = '0;
      DSP_B      = '0;
    end

    S_READY = s_rdy;
  end

  // State, counters and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      drain_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
`ifdef DSP_MAC_SAT_EN
      r_sat_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      drain_q   <= drain_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
`ifdef DSP_MAC_SAT_EN
      r_sat_q   <= r_sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a simple slice emulation closes the loop on
// DSP_P; a frame-level model checks every cycle, and a table of frames plus
// a few hand sequences cover latency, gaps, backpressure and reset.
module tb_dsp_mac_sequencer;

  localparam int unsigned NT  = 4;
  localparam int unsigned LT  = 3;
`ifdef DSP_MAC_SAT_EN
  localparam int unsigned TSW = 32;
`else
  localparam int unsigned TSW = 36;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [17:0] S_SAMPLE = '0;
  logic [17:0] S_COEF = '0;
  logic [17:0] DSP_A, DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE, DSP_RST;
  logic [47:0] DSP_P;
  logic        R_VALID;
  logic        R_READY = 1'b1;
  logic [47:0] R_DATA;
`ifdef DSP_MAC_SAT_EN
  logic        R_SAT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.N_TAPS(NT), .LAT(LT), .SAT_W(TSW)) dut (
    .CLK(clk), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_SAMPLE(S_SAMPLE), .S_COEF(S_COEF), .DSP_A(DSP_A), .DSP_B(DSP_B),
    .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_RST(DSP_RST), .DSP_P(DSP_P),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA)
`ifdef DSP_MAC_SAT_EN
    , .R_SAT(R_SAT)
`endif
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result of a frame from its plain arithmetic sum
  function automatic void ref_result(input logic [47:0] acc, output logic [47:0] d, output bit s);
    d = acc;
    s = 1'b0;
`ifdef DSP_MAC_SAT_EN
    if (acc >= (48'd1 << TSW)) begin
      d = (48'd1 << TSW) - 48'd1;
      s = 1'b1;
    end
`endif
  endfunction

  // Slice emulation: A/B, M and P registered; OPMODE travels with the operands
  logic [17:0] sl_a = '0, sl_b = '0;
  logic [47:0] sl_m = '0, sl_p = '0;
  logic [7:0]  sl_op1 = 8'h1F, sl_op2 = 8'h1F;
  assign DSP_P = sl_p;
  always @(posedge clk) begin
    if (DSP_RST) begin
      sl_a <= '0; sl_b <= '0; sl_m <= '0; sl_p <= '0;
      sl_op1 <= 8'h1F; sl_op2 <= 8'h1F;
    end else if (DSP_CE) begin
      sl_a   <= DSP_A;
      sl_b   <= DSP_B;
      sl_op1 <= DSP_OPMODE;
      sl_m   <= 48'(sl_a) * 48'(sl_b);
      sl_op2 <= sl_op1;
      case (sl_op2)
        8'h1E:   sl_p <= sl_m;
        8'h16:   sl_p <= sl_p + sl_m;
        default: sl_p <= sl_p;
      endcase
    end
  end

  // Frame-level model: taps seen, running sum, drain cycles left, result pending
  int          m_taps = 0;
  int          m_drain = 0;
  bit          m_rv = 1'b0;
  logic [47:0] m_acc = '0;
  logic [47:0] m_res = '0;
  bit          m_sat = 1'b0;
  logic [7:0]  op_log[$];

  always @(negedge clk) begin
    bit acc_now;
    bit exp_ready;
    if (RST) begin
      chk1("rst_s_ready", S_READY, 1'b0);
      chk1("rst_ce", DSP_CE, 1'b0);
      chk("rst_opmode", 48'(DSP_OPMODE), 48'h1F);
      chk1("rst_dsp_rst", DSP_RST, 1'b1);
      chk("rst_dsp_a", 48'(DSP_A), 48'd0);
      m_taps = 0; m_acc = '0; m_drain = 0; m_rv = 1'b0;
    end else begin
      exp_ready = !m_rv && (m_drain == 0);
      acc_now   = S_VALID && exp_ready;
      chk1("s_ready", S_READY, exp_ready);
      chk1("r_valid", R_VALID, m_rv);
      chk1("dsp_rst", DSP_RST, 1'b0);
      chk1("dsp_ce", DSP_CE, acc_now || (m_drain > 0));
      if (DSP_CE) op_log.push_back(DSP_OPMODE);
      if (m_rv) begin
        chk("r_data", R_DATA, m_res);
`ifdef DSP_MAC_SAT_EN
        chk1("r_sat", R_SAT, m_sat);
`endif
        if (R_READY) m_rv = 1'b0;
      end
      if (acc_now) begin
        chk("opmode_tap", 48'(DSP_OPMODE), (m_taps == 0) ? 48'h1E : 48'h16);
        chk("dsp_a", 48'(DSP_A), 48'(S_SAMPLE));
        chk("dsp_b", 48'(DSP_B), 48'(S_COEF));
        m_acc = ((m_taps == 0) ? 48'd0 : m_acc) + 48'(S_SAMPLE) * 48'(S_COEF);
        m_taps++;
        if (m_taps == NT) begin
          ref_result(m_acc, m_res, m_sat);
          m_taps  = 0;
          m_drain = LT;
        end
      end else if (m_drain > 0) begin
        chk("opmode_drain", 48'(DSP_OPMODE), 48'h17);
        chk("drain_a", 48'(DSP_A), 48'd0);
        chk("drain_b", 48'(DSP_B), 48'd0);
        m_drain--;
        if (m_drain == 0) m_rv = 1'b1;
      end
    end
  end

  // Offer one pair and wait (bounded) until it is taken
  task automatic send(input logic [17:0] s, input logic [17:0] c);
    bit taken = 1'b0;
    S_VALID = 1'b1; S_SAMPLE = s; S_COEF = c;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      taken = S_READY;
    end
    chk1("send_accepted", taken, 1'b1);
    @(posedge clk); #1;
    S_VALID = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0][17:0] s;   // pair t uses s[t]/c[t]
    logic [3:0][17:0] c;
    int               gap;
    int               hold;
    logic [47:0]      exp;
    bit               sat;
  } frame_t;

  frame_t tbl[6];
  logic [7:0] exp_ops[7];

  initial begin
    bit done;
    // (262143^2)*4 = 0x3F_FFE0_0004
`ifdef DSP_MAC_SAT_EN
    logic [47:0] max_exp = 48'hFFFF_FFFF;
    bit          max_sat = 1'b1;
`else
    logic [47:0] max_exp = 48'h3F_FFE0_0004;
    bit          max_sat = 1'b0;
`endif
    tbl[0] = '{s: {18'd2, 18'd2, 18'd2, 18'd2}, c: {18'd3, 18'd3, 18'd3, 18'd3},
               gap: 0, hold: 0, exp: 48'd24, sat: 1'b0};
    tbl[1] = '{s: {18'd4, 18'd3, 18'd2, 18'd1}, c: {18'd8, 18'd7, 18'd6, 18'd5},
               gap: 0, hold: 0, exp: 48'd70, sat: 1'b0};
    tbl[2] = '{s: {18'd4, 18'd3, 18'd2, 18'd1}, c: {18'd8, 18'd7, 18'd6, 18'd5},
               gap: 2, hold: 0, exp: 48'd70, sat: 1'b0};
    tbl[3] = '{s: {18'd4, 18'd3, 18'd2, 18'd1}, c: {18'd8, 18'd7, 18'd6, 18'd5},
               gap: 0, hold: 5, exp: 48'd70, sat: 1'b0};
    tbl[4] = '{s: {18'd1, 18'd1, 18'd1, 18'd1}, c: {18'd1, 18'd1, 18'd1, 18'd1},
               gap: 0, hold: 0, exp: 48'd4, sat: 1'b0};
    tbl[5] = '{s: {4{18'h3FFFF}}, c: {4{18'h3FFFF}},
               gap: 0, hold: 0, exp: max_exp, sat: max_sat};
    exp_ops = '{8'h1E, 8'h16, 8'h16, 8'h16, 8'h17, 8'h17, 8'h17};

    // Reset with S_VALID asserted: nothing accepted, outputs at reset values
    S_VALID = 1'b1; S_SAMPLE = 18'd9; S_COEF = 18'd9;
    repeat (2) tick();
    @(negedge clk);
    chk1("reset_r_valid", R_VALID, 1'b0);
    chk("reset_r_data", R_DATA, 48'd0);
`ifdef DSP_MAC_SAT_EN
    chk1("reset_r_sat", R_SAT, 1'b0);
`endif
    chk1("reset_s_ready", S_READY, 1'b0);
    chk("reset_opmode", 48'(DSP_OPMODE), 48'h1F);
    tick();
    RST = 1'b0; S_VALID = 1'b0;
    tick();

    // Reset after two accepts: slice flushed, no result ever appears
    send(18'd7, 18'd9);
    send(18'd11, 18'd13);
    RST = 1'b1; S_VALID = 1'b1;
    @(negedge clk);
    chk1("midrst_dsp_rst", DSP_RST, 1'b1);
    chk1("midrst_s_ready", S_READY, 1'b0);
    tick();
    RST = 1'b0; S_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("midrst_no_result", R_VALID, 1'b0);
    end
    tick();

    // Table of full frames
    for (int f = 0; f < 6; f++) begin
      op_log.delete();
      R_READY = (tbl[f].hold == 0);
      for (int t = 0; t < 4; t++) begin
        send(tbl[f].s[t], tbl[f].c[t]);
        if (t != 3) repeat (tbl[f].gap) tick();
      end
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        done = R_VALID;
      end
      chk1("result_valid", R_VALID, 1'b1);
      chk("result_data", R_DATA, tbl[f].exp);
`ifdef DSP_MAC_SAT_EN
      chk1("result_sat", R_SAT, tbl[f].sat);
`endif
      tick();
      if (tbl[f].hold > 0) begin
        S_VALID = 1'b1;
        for (int h = 0; h < tbl[f].hold; h++) begin
          @(negedge clk);
          chk("hold_data", R_DATA, tbl[f].exp);
          chk1("hold_valid", R_VALID, 1'b1);
          chk1("hold_s_ready", S_READY, 1'b0);
          tick();
        end
        S_VALID = 1'b0;
        R_READY = 1'b1;
        tick();
        @(negedge clk);
        chk1("ready_after_handshake", S_READY, 1'b1);
        chk1("valid_after_handshake", R_VALID, 1'b0);
        tick();
      end
      chk("op_seq_len", 48'(op_log.size()), 48'd7);
      for (int i = 0; i < 7; i++) begin
        if (i < op_log.size()) chk("op_seq", 48'(op_log[i]), 48'(exp_ops[i]));
      end
    end

    // Random traffic, backpressure and occasional resets against the model
    for (int i = 0; i < 600; i++) begin
      S_VALID  = ($urandom_range(0, 3) != 0);
      S_SAMPLE = 18'($urandom);
      S_COEF   = 18'($urandom);
      R_READY  = ($urandom_range(0, 2) != 0);
      RST      = ($urandom_range(0, 149) == 0);
      tick();
    end
    S_VALID = 1'b0; R_READY = 1'b1; RST = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
